// File: rtl/echo_sum_accumulator.sv
// Coherent echo summation: equal-index ADC samples of every echo are summed in RAM,
// then the per-index sums are drained over a valid/ready stream.
//   state  | meaning
//   IDLE   | waiting for START; config checked and latched here
//   ACCUM  | read-modify-write accumulation of incoming samples
//   FLUSH  | final write commits; first drain read is issued
//   DRAIN  | sums streamed out in index order
module echo_sum_accumulator #(
    parameter int ADC_DATA_WIDTH         = 16,
    parameter int ACC_WIDTH              = 32,
    parameter int ADDR_WIDTH             = 10,
    parameter int SAMPLES_PER_ECHO_WIDTH = 32,
    parameter int ECHO_PER_SCAN_WIDTH    = 32
) (
    input  logic                              ADC_CLK,
    input  logic                              RESET_N,
    input  logic                              START,
    input  logic [SAMPLES_PER_ECHO_WIDTH-1:0] SAMPLES_PER_ECHO,
    input  logic [ECHO_PER_SCAN_WIDTH-1:0]    ECHO_PER_SCAN,
    input  logic [ADC_DATA_WIDTH-1:0]         ADC_IN_DATA,
    input  logic                              ADC_IN_VALID,
    output logic [ACC_WIDTH-1:0]              SUM_OUT_DATA,
    output logic                              SUM_OUT_VALID,
    input  logic                              SUM_OUT_READY,
    output logic                              BUSY,
    output logic                              DONE,
    output logic                              CFG_ERR,
    output logic                              OVERRUN
);
    localparam int MAX_SAMPLES = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DRAIN} state_t;

    state_t                         state_q;
    logic [ADDR_WIDTH:0]            spe_q;
    logic [ECHO_PER_SCAN_WIDTH-1:0] eps_q;
    logic [ADDR_WIDTH-1:0]          idx_q;
    logic [ECHO_PER_SCAN_WIDTH-1:0] echo_q;

    logic                           p_vld_q, p_first_q;
    logic [ADDR_WIDTH-1:0]          p_addr_q;
    logic [ADC_DATA_WIDTH-1:0]      p_data_q;

    logic [ACC_WIDTH-1:0]           mem [MAX_SAMPLES];
    logic [ACC_WIDTH-1:0]           ram_rd_q, fwd_data_q;
    logic                           fwd_q;

    logic [ADDR_WIDTH:0]            drd_idx_q;
    logic                           rd_pend_q;
    logic                           out_vld_q, skid_vld_q;
    logic [ACC_WIDTH-1:0]           out_data_q, skid_data_q;
    logic                           done_q, cfg_err_q, overrun_q;

    logic [ACC_WIDTH-1:0]           rd_word, wr_data;
    logic [ADDR_WIDTH-1:0]          rd_addr;
    logic                           wr_en, xfer, rd_issue, last_xfer, cfg_bad, last_idx, last_echo;
    logic [1:0]                     occ_d;

    always_comb begin
        rd_word   = fwd_q ? fwd_data_q : ram_rd_q;
        wr_en     = p_vld_q;
        wr_data   = p_first_q ? ACC_WIDTH'(p_data_q) : rd_word + ACC_WIDTH'(p_data_q);
        rd_addr   = (state_q == S_ACCUM) ? idx_q : drd_idx_q[ADDR_WIDTH-1:0];
        xfer      = out_vld_q & SUM_OUT_READY;
        // Words held or in flight after this cycle's transfer; at most two fit (output + skid).
        occ_d     = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_pend_q} - {1'b0, xfer};
        rd_issue  = (state_q == S_FLUSH) ||
                    ((state_q == S_DRAIN) && (drd_idx_q != spe_q) && (occ_d < 2'd2));
        last_xfer = xfer && !skid_vld_q && !rd_pend_q && (drd_idx_q == spe_q);
        cfg_bad   = (SAMPLES_PER_ECHO == '0) || (ECHO_PER_SCAN == '0) ||
                    (SAMPLES_PER_ECHO > SAMPLES_PER_ECHO_WIDTH'(MAX_SAMPLES));
        last_idx  = ({1'b0, idx_q} == spe_q - (ADDR_WIDTH + 1)'(1));
        last_echo = (echo_q == eps_q - ECHO_PER_SCAN_WIDTH'(1));
    end

    always_ff @(posedge ADC_CLK) begin
        if (wr_en) mem[p_addr_q] <= wr_data;
        ram_rd_q <= mem[rd_addr];
    end

    always_ff @(posedge ADC_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            spe_q       <= '0;
            eps_q       <= '0;
            idx_q       <= '0;
            echo_q      <= '0;
            p_vld_q     <= 1'b0;
            p_first_q   <= 1'b0;
            p_addr_q    <= '0;
            p_data_q    <= '0;
            fwd_q       <= 1'b0;
            fwd_data_q  <= '0;
            drd_idx_q   <= '0;
            rd_pend_q   <= 1'b0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            p_vld_q    <= 1'b0;
            // RAM returns old data on a same-address read/write; the pending value is forwarded instead.
            fwd_q      <= wr_en && (p_addr_q == rd_addr);
            fwd_data_q <= wr_data;
            rd_pend_q  <= rd_issue;
            if (rd_issue) drd_idx_q <= drd_idx_q + 1'b1;
            if (ADC_IN_VALID && (state_q != S_ACCUM)) overrun_q <= 1'b1;

            if (!out_vld_q || xfer) begin
                if (skid_vld_q) begin
                    out_vld_q   <= 1'b1;
                    out_data_q  <= skid_data_q;
                    skid_vld_q  <= rd_pend_q;
                    skid_data_q <= rd_word;
                end else begin
                    out_vld_q  <= rd_pend_q;
                    out_data_q <= rd_word;
                end
            end else if (rd_pend_q) begin
                skid_vld_q  <= 1'b1;
                skid_data_q <= rd_word;
            end

            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            spe_q     <= SAMPLES_PER_ECHO[ADDR_WIDTH:0];
                            eps_q     <= ECHO_PER_SCAN;
                            idx_q     <= '0;
                            echo_q    <= '0;
                            drd_idx_q <= '0;
                            overrun_q <= 1'b0;
                            state_q   <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (ADC_IN_VALID) begin
                        p_vld_q   <= 1'b1;
                        p_addr_q  <= idx_q;
                        p_data_q  <= ADC_IN_DATA;
                        p_first_q <= (echo_q == '0);
                        if (last_idx) begin
                            idx_q <= '0;
                            if (last_echo) state_q <= S_FLUSH;
                            else           echo_q  <= echo_q + 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: state_q <= S_DRAIN;
                S_DRAIN: begin
                    if (last_xfer) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign SUM_OUT_DATA  = out_data_q;
    assign SUM_OUT_VALID = out_vld_q;
    assign BUSY          = (state_q != S_IDLE);
    assign DONE          = done_q;
    assign CFG_ERR       = cfg_err_q;
    assign OVERRUN       = overrun_q;
endmodule

// File: tb/tb_echo_sum_accumulator.sv
// Bench for echo_sum_accumulator: directed scans with literal sums plus randomized scans
// checked against a per-index summation model; the output stream is checked every cycle.
module tb_echo_sum_accumulator;
    logic        ADC_CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic [31:0] SAMPLES_PER_ECHO = '0;
    logic [31:0] ECHO_PER_SCAN = '0;
    logic [15:0] ADC_IN_DATA = '0;
    logic        ADC_IN_VALID = 1'b0;
    logic [31:0] SUM_OUT_DATA;
    logic        SUM_OUT_VALID;
    logic        SUM_OUT_READY = 1'b1;
    logic        BUSY, DONE, CFG_ERR, OVERRUN;

    int          errs = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [15:0] stim_q[$];
    int          rmode = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          last_xfer_cyc = -10;
    bit          hold_pend = 1'b0;
    logic [31:0] hold_data = '0;
    bit [5:0]    ready_pat = 6'b101001;

    echo_sum_accumulator dut (
        .ADC_CLK(ADC_CLK), .RESET_N(RESET_N), .START(START),
        .SAMPLES_PER_ECHO(SAMPLES_PER_ECHO), .ECHO_PER_SCAN(ECHO_PER_SCAN),
        .ADC_IN_DATA(ADC_IN_DATA), .ADC_IN_VALID(ADC_IN_VALID),
        .SUM_OUT_DATA(SUM_OUT_DATA), .SUM_OUT_VALID(SUM_OUT_VALID), .SUM_OUT_READY(SUM_OUT_READY),
        .BUSY(BUSY), .DONE(DONE), .CFG_ERR(CFG_ERR), .OVERRUN(OVERRUN)
    );

    always #5 ADC_CLK = ~ADC_CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Output stream monitor: ordering, stall stability, DONE timing.
    always @(negedge ADC_CLK) begin
        cyc++;
        if (!RESET_N) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("stall_valid_held", SUM_OUT_VALID, 1);
                check("stall_data_held", SUM_OUT_DATA, hold_data);
            end
            if (SUM_OUT_VALID && SUM_OUT_READY) begin
                if (exp_q.size() == 0) check("words_expected", exp_q.size(), 1);
                else                   check("sum_word", SUM_OUT_DATA, exp_q.pop_front());
                last_xfer_cyc = cyc;
            end
            if (DONE) begin
                done_cnt++;
                check("done_after_last_xfer", cyc - last_xfer_cyc, 1);
                check("done_queue_empty", exp_q.size(), 0);
                check("valid_low_at_done", SUM_OUT_VALID, 0);
            end
            hold_pend = SUM_OUT_VALID && !SUM_OUT_READY;
            hold_data = SUM_OUT_DATA;
        end
    end

    initial begin
        int pidx = 0;
        forever begin
            @(posedge ADC_CLK);
            #1;
            case (rmode)
                0: SUM_OUT_READY = 1'b1;
                1: begin
                    SUM_OUT_READY = ready_pat[pidx];
                    pidx = (pidx + 1) % 6;
                end
                default: SUM_OUT_READY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference: sum of all samples whose stream position maps to the same index.
    task automatic model_push(input int spe);
        logic [31:0] s[];
        s = new[spe];
        foreach (s[i]) s[i] = '0;
        foreach (stim_q[k]) s[k % spe] += 32'(stim_q[k]);
        foreach (s[i]) exp_q.push_back(s[i]);
    endtask

    task automatic start_scan(input int spe, input int eps);
        @(posedge ADC_CLK);
        #1;
        SAMPLES_PER_ECHO = spe;
        ECHO_PER_SCAN = eps;
        START = 1'b1;
        @(posedge ADC_CLK);
        #1;
        START = 1'b0;
        SAMPLES_PER_ECHO = $urandom;
        ECHO_PER_SCAN = $urandom;
        check("busy_after_start", BUSY, 1);
        check("overrun_cleared_by_start", OVERRUN, 0);
    endtask

    task automatic send_stim(input int gap_max);
        int g;
        foreach (stim_q[k]) begin
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            repeat (g) begin
                ADC_IN_VALID = 1'b0;
                START = ($urandom_range(0, 3) == 0);
                SAMPLES_PER_ECHO = $urandom_range(1, 8);
                ECHO_PER_SCAN = 1;
                @(posedge ADC_CLK);
                #1;
            end
            START = 1'b0;
            ADC_IN_VALID = 1'b1;
            ADC_IN_DATA = stim_q[k];
            @(posedge ADC_CLK);
            #1;
        end
        ADC_IN_VALID = 1'b0;
        ADC_IN_DATA = 16'($urandom);
    endtask

    task automatic finish_scan();
        int n;
        n = 0;
        do begin
            @(negedge ADC_CLK);
            n++;
        end while (!SUM_OUT_VALID && n < 10);
        check("first_valid_latency", n, 3);
        n = 0;
        while (!DONE && n < 5000) begin
            @(negedge ADC_CLK);
            n++;
        end
        check("done_seen", DONE, 1);
        @(negedge ADC_CLK);
        check("busy_low_after_done", BUSY, 0);
        check("overrun_clear_after_scan", OVERRUN, 0);
        @(posedge ADC_CLK);
        #1;
    endtask

    task automatic cfg_reject(input int spe, input int eps, input string nm);
        @(posedge ADC_CLK);
        #1;
        SAMPLES_PER_ECHO = spe;
        ECHO_PER_SCAN = eps;
        START = 1'b1;
        @(posedge ADC_CLK);
        #1;
        START = 1'b0;
        check({nm, "_cfg_err_pulse"}, CFG_ERR, 1);
        check({nm, "_busy_low"}, BUSY, 0);
        @(posedge ADC_CLK);
        #1;
        check({nm, "_cfg_err_one_cycle"}, CFG_ERR, 0);
        check({nm, "_still_idle"}, BUSY, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] lit[4];
        int d, spe, eps, gm;

        repeat (3) @(posedge ADC_CLK);
        #1;
        check("reset_busy", BUSY, 0);
        check("reset_valid", SUM_OUT_VALID, 0);
        check("reset_done", DONE, 0);
        check("reset_cfg_err", CFG_ERR, 0);
        check("reset_overrun", OVERRUN, 0);
        RESET_N = 1'b1;
        @(posedge ADC_CLK);
        #1;
        check("idle_after_reset", BUSY, 0);

        // Scenario 1: 4 x 3 incrementing samples, model pinned against hand sums
        stim_q.delete();
        for (int k = 0; k < 12; k++) stim_q.push_back(16'(100 + k));
        lit = '{312, 315, 318, 321};
        exp_q.delete();
        model_push(4);
        for (int i = 0; i < 4; i++) check("model_pin", exp_q[i], lit[i]);
        rmode = 0;
        start_scan(4, 3);
        send_stim(0);
        finish_scan();

        // Scenario 2: single-sample echoes exercise forwarding
        stim_q = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
        exp_q = '{32'd150};
        start_scan(1, 5);
        send_stim(0);
        finish_scan();

        // Scenario 3: scenario 1 under a stalling READY pattern
        stim_q.delete();
        for (int k = 0; k < 12; k++) stim_q.push_back(16'(100 + k));
        exp_q = '{32'd312, 32'd315, 32'd318, 32'd321};
        rmode = 1;
        start_scan(4, 3);
        send_stim(0);
        finish_scan();
        rmode = 0;

        // Rejected configurations and IDLE overrun
        cfg_reject(0, 3, "spe_zero");
        cfg_reject(1025, 3, "spe_too_big");
        cfg_reject(4, 0, "eps_zero");
        @(posedge ADC_CLK);
        #1;
        ADC_IN_VALID = 1'b1;
        ADC_IN_DATA = 16'h1234;
        @(posedge ADC_CLK);
        #1;
        ADC_IN_VALID = 1'b0;
        check("overrun_set_in_idle", OVERRUN, 1);
        @(posedge ADC_CLK);
        #1;
        check("overrun_sticky", OVERRUN, 1);

        // Abort mid-scan during echo 1
        stim_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        start_scan(4, 3);
        send_stim(0);
        exp_q.delete();
        d = done_cnt;
        RESET_N = 1'b0;
        #1;
        check("abort_busy", BUSY, 0);
        check("abort_valid", SUM_OUT_VALID, 0);
        check("abort_data", SUM_OUT_DATA, 0);
        check("abort_done", DONE, 0);
        check("abort_overrun", OVERRUN, 0);
        repeat (3) @(posedge ADC_CLK);
        #1;
        RESET_N = 1'b1;
        repeat (4) @(posedge ADC_CLK);
        #1;
        check("no_done_after_abort", done_cnt, d);
        check("idle_after_abort", BUSY, 0);

        stim_q = '{16'd7, 16'd8, 16'd9, 16'd10};
        exp_q = '{32'd16, 32'd18};
        start_scan(2, 2);
        send_stim(0);
        finish_scan();

        // Full-scale samples carry beyond 16 bits
        stim_q = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        exp_q = '{32'h2FFFD, 32'h2FFFD};
        start_scan(2, 3);
        send_stim(0);
        finish_scan();

        // Randomized scans against the model
        rmode = 2;
        for (int s = 0; s < 12; s++) begin
            spe = $urandom_range(1, 12);
            eps = $urandom_range(1, 4);
            gm  = $urandom_range(0, 2);
            stim_q.delete();
            for (int k = 0; k < spe * eps; k++)
                stim_q.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
            exp_q.delete();
            model_push(spe);
            start_scan(spe, eps);
            send_stim(gm);
            finish_scan();
        end

        // Largest legal echo length
        stim_q.delete();
        for (int k = 0; k < 2048; k++) stim_q.push_back(16'($urandom));
        exp_q.delete();
        model_push(1024);
        start_scan(1024, 2);
        send_stim(0);
        finish_scan();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
